// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run controller for the CPU under test. After a start pulse it holds the CPU
//   in reset for a fixed number of cycles. It then enables the CPU until one of
//   three things happens: the program halts (the PC repeats), the cycle budget
//   runs out, or an abort arrives. It then freezes the CPU and reports how the
//   run ended and how many enabled cycles it took.
//
//   Optional feature macro: RUN_CTRL_STEP_EN
//     When defined, adds step_mode/step inputs. These allow single-stepping the
//     CPU one enabled cycle per step pulse.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   1-cycle pulse, begins a run from IDLE or DONE
//   abort        in   ends a run from RST or RUN with no flags set
//   step_mode    in   (RUN_CTRL_STEP_EN only) 1 = single-step in RUN
//   step         in   (RUN_CTRL_STEP_EN only) pulse granting one enabled cycle
//   pc           in   CPU program counter, sampled on enabled cycles
//   cpu_reset    out  reset to the CPU
//   cpu_en       out  clock-enable to the CPU
//   busy         out  high in RST or RUN
//   done         out  high in DONE
//   halted       out  last run ended on a PC self-loop
//   timeout      out  last run ended on budget exhaustion
//   cycle_count  out  enabled CPU cycles in the current/last run
module cpu_run_ctrl #(
  parameter int ADDR_W       = 64,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 200,
  parameter int HALT_REPEAT  = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
`ifdef RUN_CTRL_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  // A reset length of 0 still needs one cycle of cpu_reset, and a halt needs
  // at least two identical samples to be a self-loop.
  localparam int RST_LEN  = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int RST_W    = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam int HALT_LEN = (HALT_REPEAT < 2) ? 2 : HALT_REPEAT;

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] SAME_LAST = CNT_W'(HALT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [RST_W-1:0]  rst_cnt;
  logic [CNT_W-1:0]  same_cnt;
  logic [CNT_W-1:0]  same_next;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] pc_prev;
  logic              have_prev;
  logic              run_grant;
  logic              enabled;
  logic              halt_hit;
  logic              budget_hit;
  logic              start_run;

  // run_grant is registered so that cpu_en remains a pure function of
  // registered state, even in step mode.
`ifdef RUN_CTRL_STEP_EN
  logic step_ok;

  // In step mode, a step pulse grants exactly the following cycle. A pulse that
  // lands on a granted cycle is dropped. With step_mode low, every cycle is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_ok <= 1'b0;
    end else if (!step_mode) begin
      step_ok <= 1'b1;
    end else begin
      step_ok <= step && !step_ok;
    end
  end

  assign run_grant = step_ok;
`else
  assign run_grant = 1'b1;
`endif

  // Exit conditions are computed for the edge that ends the current enabled
  // cycle. A halt needs HALT_LEN identical samples, which is HALT_LEN-1
  // consecutive matches against the previous sample.
  always_comb begin
    enabled    = (state == S_RUN) && run_grant;
    count_next = cycle_count + CNT_W'(1);
    same_next  = (have_prev && (pc == pc_prev)) ? same_cnt + CNT_W'(1) : '0;
    halt_hit   = (same_next >= SAME_LAST);
    budget_hit = (count_next >= MAX_CNT);
    start_run  = start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_next = state;
    cpu_reset  = 1'b0;
    cpu_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        if (start) state_next = S_RST;
      end
      S_RST: begin
        cpu_reset = 1'b1;
        busy      = 1'b1;
        if (abort) begin
          state_next = S_DONE;
        end else if (rst_cnt == RST_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        cpu_en = run_grant;
        busy   = 1'b1;
        if (abort) begin
          state_next = S_DONE;
        end else if (enabled && (halt_hit || budget_hit)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_RST;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Run bookkeeping. Counters and the halt compare advance only on enabled
  // cycles. The flags are written on every enabled cycle, but they can only
  // become set on the exit edge. An abort on that edge suppresses both flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_cnt     <= '0;
      cycle_count <= '0;
      same_cnt    <= '0;
      pc_prev     <= '0;
      have_prev   <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else if (start_run) begin
      rst_cnt     <= '0;
      cycle_count <= '0;
      same_cnt    <= '0;
      pc_prev     <= '0;
      have_prev   <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else if (state == S_RST) begin
      rst_cnt <= rst_cnt + RST_W'(1);
    end else if (enabled) begin
      cycle_count <= count_next;
      pc_prev     <= pc;
      have_prev   <= 1'b1;
      same_cnt    <= same_next;
      if (!abort) begin
        halted  <= halt_hit;
        timeout <= budget_hit && !halt_hit;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
//   Directed bench for cpu_run_ctrl. It runs two instances side by side on the
//   same stimulus: one with default parameters, and one with MAX_CYCLES=19, so
//   that the halt and budget conditions land on the same edge. The pc stream
//   acts like a small CPU: pc advances only when the controller enables it.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] pc;
`ifdef RUN_CTRL_STEP_EN
  logic        step_mode;
  logic        step;
`endif

  logic        cpu_reset, cpu_en, busy, done, halted, timeout;
  logic [15:0] cycle_count;
  logic        s_cpu_reset, s_cpu_en, s_busy, s_done, s_halted, s_timeout;
  logic [15:0] s_cycle_count;

  int vec_count;
  int miscompares;

  cpu_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
`ifdef RUN_CTRL_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .pc          (pc),
    .cpu_reset   (cpu_reset),
    .cpu_en      (cpu_en),
    .busy        (busy),
    .done        (done),
    .halted      (halted),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  cpu_run_ctrl #(.MAX_CYCLES(19)) dut_short (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
`ifdef RUN_CTRL_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .pc          (pc),
    .cpu_reset   (s_cpu_reset),
    .cpu_en      (s_cpu_en),
    .busy        (s_busy),
    .done        (s_done),
    .halted      (s_halted),
    .timeout     (s_timeout),
    .cycle_count (s_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The whole run is a few thousand cycles; anything longer means a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode 0: pc += 4 on every enabled cycle. Mode 1: pc counts 0..0x40 over
  // enabled cycles 1-17, then holds at 0x40.
  function automatic logic [63:0] pcModel(input int mode, input int n);
    logic [63:0] v;
    v = 64'(4 * (n - 1));
    if (mode == 1 && n > 17) v = 64'h40;
    return v;
  endfunction

  // Starts one run and drives pc each enabled cycle until done. Three optional
  // events can be scheduled: abort (on an enabled cycle), an async reset (on an
  // enabled cycle), and a start pulse at enabled cycle 5, which must be ignored.
  task automatic applyStimulus(input int mode, input int abort_at, input int reset_at,
                               output int en_cycles, output int rst_cycles);
    bit hit_reset;
    hit_reset  = 1'b0;
    en_cycles  = 0;
    rst_cycles = 0;
    @(negedge clk);
    start = 1'b1;
    pc    = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_busy",     64'(busy),        64'(1));
    checkOutput("rst_cpu_en",   64'(cpu_en),      64'(0));
    checkOutput("rst_clr_cnt",  64'(cycle_count), 64'(0));
    checkOutput("rst_clr_halt", 64'(halted),      64'(0));
    checkOutput("rst_clr_to",   64'(timeout),     64'(0));
    for (int i = 0; i < 400 && !done && !hit_reset; i++) begin
      if (busy && cpu_reset) rst_cycles++;
      start = 1'b0;
      abort = 1'b0;
      if (cpu_en) begin
        en_cycles++;
        pc    = pcModel(mode, en_cycles);
        start = (en_cycles == 5);
        abort = (en_cycles == abort_at);
        if (en_cycles == reset_at) begin
          #2 reset = 1'b1;
          #1;
          checkOutput("arst_cpu_reset", 64'(cpu_reset),   64'(1));
          checkOutput("arst_cpu_en",    64'(cpu_en),      64'(0));
          checkOutput("arst_busy",      64'(busy),        64'(0));
          checkOutput("arst_done",      64'(done),        64'(0));
          checkOutput("arst_halted",    64'(halted),      64'(0));
          checkOutput("arst_timeout",   64'(timeout),     64'(0));
          checkOutput("arst_count",     64'(cycle_count), 64'(0));
          hit_reset = 1'b1;
        end
      end
      if (!hit_reset) @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    if (hit_reset) begin
      @(negedge clk);
      reset = 1'b0;
    end else begin
      checkOutput("done_bound", 64'(done), 64'(1));
    end
  endtask

  task automatic expectEnd(input string tag, input logic exp_halt, input logic exp_to,
                           input int exp_cnt, input int en_cycles, input int rst_cycles);
    checkOutput({tag, "_done"},    64'(done),        64'(1));
    checkOutput({tag, "_busy"},    64'(busy),        64'(0));
    checkOutput({tag, "_cpu_en"},  64'(cpu_en),      64'(0));
    checkOutput({tag, "_cpu_rst"}, 64'(cpu_reset),   64'(0));
    checkOutput({tag, "_halted"},  64'(halted),      64'(exp_halt));
    checkOutput({tag, "_timeout"}, 64'(timeout),     64'(exp_to));
    checkOutput({tag, "_count"},   64'(cycle_count), 64'(exp_cnt));
    checkOutput({tag, "_en_cyc"},  64'(en_cycles),   64'(exp_cnt));
    checkOutput({tag, "_rst_cyc"}, 64'(rst_cycles),  64'(1));
  endtask

  int en_cycles;
  int rst_cycles;

  initial begin
    vec_count   = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pc    = '0;
`ifdef RUN_CTRL_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    #3;
    checkOutput("por_cpu_reset", 64'(cpu_reset),   64'(1));
    checkOutput("por_cpu_en",    64'(cpu_en),      64'(0));
    checkOutput("por_busy",      64'(busy),        64'(0));
    checkOutput("por_done",      64'(done),        64'(0));
    checkOutput("por_count",     64'(cycle_count), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cpu_reset", 64'(cpu_reset), 64'(1));
    checkOutput("idle_busy",      64'(busy),      64'(0));

    // Budget exhaustion: 200 enabled cycles. The short instance hits its budget of 19 first.
    applyStimulus(0, 0, 0, en_cycles, rst_cycles);
    expectEnd("t1", 1'b0, 1'b1, 200, en_cycles, rst_cycles);
    checkOutput("t1s_timeout", 64'(s_timeout),     64'(1));
    checkOutput("t1s_halted",  64'(s_halted),      64'(0));
    checkOutput("t1s_count",   64'(s_cycle_count), 64'(19));

    // PC self-loop: halts after enabled cycle 19. In the short instance the
    // budget also hits on that edge, and halt must win.
    applyStimulus(1, 0, 0, en_cycles, rst_cycles);
    expectEnd("t2", 1'b1, 1'b0, 19, en_cycles, rst_cycles);
    checkOutput("t4_halted",  64'(s_halted),      64'(1));
    checkOutput("t4_timeout", 64'(s_timeout),     64'(0));
    checkOutput("t4_count",   64'(s_cycle_count), 64'(19));

    // Abort during enabled cycle 10.
    applyStimulus(0, 10, 0, en_cycles, rst_cycles);
    expectEnd("t3", 1'b0, 1'b0, 10, en_cycles, rst_cycles);
    checkOutput("t3s_count", 64'(s_cycle_count), 64'(10));
    // An abort while in DONE is ignored.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t3_abort_in_done", 64'(done),        64'(1));
    checkOutput("t3_count_held",    64'(cycle_count), 64'(10));

    // Async reset at enabled cycle 50, then a normal run.
    applyStimulus(0, 0, 50, en_cycles, rst_cycles);
    @(negedge clk);
    checkOutput("t5_idle_cpu_reset", 64'(cpu_reset), 64'(1));
    checkOutput("t5_idle_done",      64'(done),      64'(0));
    applyStimulus(0, 0, 0, en_cycles, rst_cycles);
    expectEnd("t5a", 1'b0, 1'b1, 200, en_cycles, rst_cycles);

    // A halted run, then a restart from DONE, which must clear the halted flag.
    applyStimulus(1, 0, 0, en_cycles, rst_cycles);
    expectEnd("t5b", 1'b1, 1'b0, 19, en_cycles, rst_cycles);
    applyStimulus(0, 0, 0, en_cycles, rst_cycles);
    expectEnd("t5c", 1'b0, 1'b1, 200, en_cycles, rst_cycles);

`ifdef RUN_CTRL_STEP_EN
    // Single-step: five step pulses 4 cycles apart grant five enabled cycles.
    begin
      int steps;
      int en_seen;
      steps     = 0;
      en_seen   = 0;
      step_mode = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (cpu_en) begin
          en_seen++;
          pc = 64'(4 * en_seen);
        end
        step = 1'b0;
        if (i >= 2 && ((i - 2) % 4) == 0 && steps < 5) begin
          step = 1'b1;
          steps++;
        end
        @(negedge clk);
      end
      step = 1'b0;
      checkOutput("t6_en_cycles", 64'(en_seen),     64'(5));
      checkOutput("t6_count",     64'(cycle_count), 64'(5));
      checkOutput("t6_busy",      64'(busy),        64'(1));
      checkOutput("t6_done",      64'(done),        64'(0));
      abort = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      step_mode = 1'b0;
      checkOutput("t6_abort_done", 64'(done), 64'(1));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
